// File: rtl/motor_pkg.sv
// -----------------------------------------------------------------------------
// motor_pkg
// Shared types, widths, default parameters and result helpers for the
// two-channel motor speed scheduler.
//   - sched_state_t : sequencing FSM states
//   - rpm_res_t     : reduced 8-bit speed plus its overflow flag
//   - abs_rev()     : magnitude of a signed revolution count (-128 -> 128)
//   - reduce_rpm()  : sign-apply and reduce a 16-bit product to 8-bit signed
// -----------------------------------------------------------------------------
package motor_pkg;

  localparam int RPM_W  = 8;
  localparam int PROD_W = 16;

  localparam int DEF_GATE_CYCLES   = 10000000;
  localparam int DEF_EDGES_PER_REV = 48;
  localparam int DEF_MULT_LAT      = 2;

  localparam logic [RPM_W-1:0] RPM_POS_MAX = 8'h7F;
  localparam logic [RPM_W-1:0] RPM_NEG_MIN = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL0,
    S_WAIT0,
    S_MUL1,
    S_WAIT1,
    S_PUBLISH
  } sched_state_t;

  typedef struct packed {
    logic             ovf;
    logic [RPM_W-1:0] value;
  } rpm_res_t;

  // Magnitude as an unsigned operand; -128 maps to 8'h80 = 128, which fits.
  function automatic logic [RPM_W-1:0] abs_rev(input logic [RPM_W-1:0] rev);
    return rev[RPM_W-1] ? (~rev + 1'b1) : rev;
  endfunction

  // Positive results may reach 127, negative ones 128. With saturation
  // enabled an out-of-range result clamps and flags; otherwise the low byte
  // of the signed product is kept.
  function automatic rpm_res_t reduce_rpm(input logic [PROD_W-1:0] prod,
                                          input logic              neg,
                                          input logic              sat);
    rpm_res_t res;
    logic     out_of_range;
    out_of_range = neg ? (prod > PROD_W'(128)) : (prod > PROD_W'(127));
    res.ovf      = sat & out_of_range;
    if (res.ovf) begin
      res.value = neg ? RPM_NEG_MIN : RPM_POS_MAX;
    end else begin
      res.value = neg ? (~prod[RPM_W-1:0] + 1'b1) : prod[RPM_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/encoder_rev_counter.sv
// -----------------------------------------------------------------------------
// encoder_rev_counter
// One quadrature channel: synchronizes A/B, detects rising edges of A,
// counts edges modulo EDGES_PER_REV and keeps a saturating signed revolution
// count. A full revolution steps the count by -1 when B is high, +1 otherwise.
// Ports:
//   cclk, rst  - clock, synchronous active-high reset
//   i_a, i_b   - raw asynchronous encoder phases
//   clear      - window boundary: restart the revolution count
//   rev_count  - signed revolution count for the current window
// -----------------------------------------------------------------------------
module encoder_rev_counter
  import motor_pkg::*;
#(
  parameter int EDGES_PER_REV = DEF_EDGES_PER_REV
) (
  input  logic                    cclk,
  input  logic                    rst,
  input  logic                    i_a,
  input  logic                    i_b,
  input  logic                    clear,
  output logic signed [RPM_W-1:0] rev_count
);

  localparam int             EW        = $clog2(EDGES_PER_REV);
  localparam logic [EW-1:0]  EDGE_LAST = EW'(EDGES_PER_REV - 1);

  logic [1:0]       r_a_sync;
  logic [1:0]       r_b_sync;
  logic             r_a_prev;
  logic [EW-1:0]    r_edge_cnt;
  logic [RPM_W-1:0] r_rev;

  logic             w_edge;
  logic             w_rev;
  logic [RPM_W-1:0] w_base;
  logic [RPM_W-1:0] w_next_rev;

  assign w_edge = r_a_sync[1] & ~r_a_prev;
  assign w_rev  = w_edge && (r_edge_cnt == EDGE_LAST);

  // A revolution completing on the clear cycle belongs to the new window,
  // so it steps from zero instead of from the old count.
  // NOTE: every combinational output gets a default before any branch; a path
  // that leaves a variable unassigned would infer a latch.
  always_comb begin
    w_base     = clear ? '0 : r_rev;
    w_next_rev = w_base;
    if (r_b_sync[1]) begin
      if (w_base != RPM_NEG_MIN) w_next_rev = w_base - 1'b1;
    end else begin
      if (w_base != RPM_POS_MAX) w_next_rev = w_base + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; the synchronizer shift depends on it.
  always_ff @(posedge cclk) begin
    if (rst) begin
      r_a_sync   <= '0;
      r_b_sync   <= '0;
      r_a_prev   <= 1'b0;
      r_edge_cnt <= '0;
      r_rev      <= '0;
    end else begin
      r_a_sync <= {r_a_sync[0], i_a};
      r_b_sync <= {r_b_sync[0], i_b};
      r_a_prev <= r_a_sync[1];
      if (w_edge) r_edge_cnt <= w_rev ? '0 : r_edge_cnt + 1'b1;
      if (w_rev) begin
        r_rev <= w_next_rev;
      end else if (clear) begin
        r_rev <= '0;
      end
    end
  end

  assign rev_count = r_rev;

endmodule

// File: rtl/motor_speed_scheduler.sv
// -----------------------------------------------------------------------------
// motor_speed_scheduler
// Two-channel motor speed measurement. Counts signed revolutions per channel
// over a gate window of GATE_CYCLES cycles, then time-shares one external
// multiplier to scale each count by its gear ratio and publishes both speeds.
// Ports:
//   cclk, rst          - clock, synchronous active-high reset
//   a0,b0,a1,b1        - raw encoder phases (asynchronous)
//   gr0, gr1           - unsigned gear ratios, sampled at the window boundary
//   mul_x, mul_y       - registered operands to the shared multiplier
//   mul_z              - product, valid MULT_LAT cycles after the operands
//   rpm0, rpm1         - signed speed per channel
//   rpm_valid          - one-cycle pulse when rpm0/rpm1 update
//   rpm_ovf            - per-channel overflow of the last published result
// Build option: define MOTOR_SPEED_SAT_EN to saturate out-of-range results
// and report them on rpm_ovf; otherwise results wrap and rpm_ovf stays 0.
// -----------------------------------------------------------------------------
module motor_speed_scheduler
  import motor_pkg::*;
#(
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int EDGES_PER_REV = DEF_EDGES_PER_REV,
  parameter int MULT_LAT      = DEF_MULT_LAT
) (
  input  logic                    cclk,
  input  logic                    rst,
  input  logic                    a0,
  input  logic                    b0,
  input  logic                    a1,
  input  logic                    b1,
  input  logic [RPM_W-1:0]        gr0,
  input  logic [RPM_W-1:0]        gr1,
  output logic [RPM_W-1:0]        mul_x,
  output logic [RPM_W-1:0]        mul_y,
  input  logic [PROD_W-1:0]       mul_z,
  output logic signed [RPM_W-1:0] rpm0,
  output logic signed [RPM_W-1:0] rpm1,
  output logic                    rpm_valid,
  output logic [1:0]              rpm_ovf
);

`ifdef MOTOR_SPEED_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  localparam int             GW         = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]  GATE_LAST  = GW'(GATE_CYCLES - 1);
  localparam int             WCW        = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(MULT_LAT - 1);

  logic [GW-1:0]     r_gate_cnt;
  logic              w_tc;
  logic [RPM_W-1:0]  w_rev0;
  logic [RPM_W-1:0]  w_rev1;

  sched_state_t      r_state;
  logic [WCW-1:0]    r_wait_cnt;
  logic [RPM_W-1:0]  r_mul_x;
  logic [RPM_W-1:0]  r_mul_y;
  logic              r_neg0;
  logic              r_neg1;
  logic [RPM_W-1:0]  r_mag1;
  logic [RPM_W-1:0]  r_gr1_snap;
  logic [PROD_W-1:0] r_prod0;
  logic [PROD_W-1:0] r_prod1;
  logic [RPM_W-1:0]  r_rpm0;
  logic [RPM_W-1:0]  r_rpm1;
  logic              r_rpm_valid;
  logic [1:0]        r_rpm_ovf;

  rpm_res_t          w_res0;
  rpm_res_t          w_res1;

  encoder_rev_counter #(.EDGES_PER_REV(EDGES_PER_REV)) u_enc0 (
    .cclk      (cclk),
    .rst       (rst),
    .i_a       (a0),
    .i_b       (b0),
    .clear     (w_tc),
    .rev_count (w_rev0)
  );

  encoder_rev_counter #(.EDGES_PER_REV(EDGES_PER_REV)) u_enc1 (
    .cclk      (cclk),
    .rst       (rst),
    .i_a       (a1),
    .i_b       (b1),
    .clear     (w_tc),
    .rev_count (w_rev1)
  );

  // Free-running gate window; it never waits for the sequencer.
  assign w_tc = (r_gate_cnt == GATE_LAST);

  always_ff @(posedge cclk) begin
    if (rst) begin
      r_gate_cnt <= '0;
    end else begin
      r_gate_cnt <= w_tc ? '0 : r_gate_cnt + 1'b1;
    end
  end

  assign w_res0 = reduce_rpm(r_prod0, r_neg0, SAT_EN);
  assign w_res1 = reduce_rpm(r_prod1, r_neg1, SAT_EN);

  // Sequencer. Channel-0 operands are loaded on the TC edge itself so they
  // are on the bus the cycle after TC; channel-1 operands are loaded on the
  // edge that captures the channel-0 product.
  always_ff @(posedge cclk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_mul_x     <= '0;
      r_mul_y     <= '0;
      r_neg0      <= 1'b0;
      r_neg1      <= 1'b0;
      r_mag1      <= '0;
      r_gr1_snap  <= '0;
      r_prod0     <= '0;
      r_prod1     <= '0;
      r_rpm0      <= '0;
      r_rpm1      <= '0;
      r_rpm_valid <= 1'b0;
      r_rpm_ovf   <= '0;
    end else begin
      r_rpm_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tc) begin
            r_mul_x    <= abs_rev(w_rev0);
            r_mul_y    <= gr0;
            r_neg0     <= w_rev0[RPM_W-1];
            r_mag1     <= abs_rev(w_rev1);
            r_neg1     <= w_rev1[RPM_W-1];
            r_gr1_snap <= gr1;
            r_state    <= S_MUL0;
          end
        end
        S_MUL0: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT0;
        end
        S_WAIT0: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_prod0 <= mul_z;
            r_mul_x <= r_mag1;
            r_mul_y <= r_gr1_snap;
            r_state <= S_MUL1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_MUL1: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT1;
        end
        S_WAIT1: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_prod1 <= mul_z;
            r_mul_x <= '0;
            r_mul_y <= '0;
            r_state <= S_PUBLISH;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_PUBLISH: begin
          r_rpm0      <= w_res0.value;
          r_rpm1      <= w_res1.value;
          r_rpm_ovf   <= {w_res1.ovf, w_res0.ovf};
          r_rpm_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mul_x     = r_mul_x;
  assign mul_y     = r_mul_y;
  assign rpm0      = r_rpm0;
  assign rpm1      = r_rpm1;
  assign rpm_valid = r_rpm_valid;
  assign rpm_ovf   = r_rpm_ovf;

endmodule

// File: tb/tb_motor_speed_scheduler.sv
// -----------------------------------------------------------------------------
// tb_motor_speed_scheduler
// Drives encoder phases and gear ratios, keeps a behavioural model of the
// revolution counts per window, and pushes the expected publish (operands,
// speeds, overflow, publish cycle) into a scoreboard at each window end.
// An independent monitor checks the DUT outputs every cycle against the
// scoreboard front entry. A pipelined multiplier model feeds mul_z.
// -----------------------------------------------------------------------------
module tb_motor_speed_scheduler;

  localparam int G   = 100;
  localparam int EPR = 4;
  localparam int L   = 2;

  typedef struct {
    int         k;
    logic [7:0] x0, y0, x1, y1;
    logic [7:0] rpm0, rpm1;
    logic [1:0] ovf;
  } exp_t;

  logic        cclk = 1'b0;
  logic        rst  = 1'b1;
  logic        a0 = 1'b0, b0 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic [7:0]  gr0 = '0, gr1 = '0;
  logic [7:0]  mul_x, mul_y;
  logic [15:0] mul_z;
  logic [7:0]  rpm0, rpm1;
  logic        rpm_valid;
  logic [1:0]  rpm_ovf;

  motor_speed_scheduler #(
    .GATE_CYCLES  (G),
    .EDGES_PER_REV(EPR),
    .MULT_LAT     (L)
  ) dut (
    .cclk      (cclk),
    .rst       (rst),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .gr0       (gr0),
    .gr1       (gr1),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_z     (mul_z),
    .rpm0      (rpm0),
    .rpm1      (rpm1),
    .rpm_valid (rpm_valid),
    .rpm_ovf   (rpm_ovf)
  );

  always #5 cclk = ~cclk;

  // Behavioural multiplier with L pipeline stages.
  logic [15:0] mpipe1 = '0, mpipe2 = '0;
  always @(posedge cclk) begin
    mpipe1 <= 16'(mul_x) * 16'(mul_y);
    mpipe2 <= mpipe1;
  end
  assign mul_z = mpipe2;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  int   mon_cyc  = 0;
  logic [7:0] pub_rpm0 = '0, pub_rpm1 = '0;
  logic [1:0] pub_ovf  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, mon_cyc, act, exp);
    end
  endtask

  // Cycle index since the last reset; a reset also drops pending publishes.
  always @(posedge cclk) begin
    if (rst) begin
      mon_cyc <= 0;
      sb_q.delete();
      pub_rpm0 = '0;
      pub_rpm1 = '0;
      pub_ovf  = '0;
    end else begin
      mon_cyc <= mon_cyc + 1;
    end
  end

  // Monitor: every cycle, compare against what the front publish implies.
  initial begin
    exp_t       e;
    logic [7:0] ex, ey;
    logic       ev;
    @(posedge cclk);
    forever begin
      @(negedge cclk);
      ex = '0; ey = '0; ev = 1'b0;
      if (sb_q.size() > 0) begin
        e = sb_q[0];
        if (mon_cyc >= e.k + 1 && mon_cyc <= e.k + 1 + L) begin
          ex = e.x0; ey = e.y0;
        end else if (mon_cyc >= e.k + 2 + L && mon_cyc <= e.k + 2 + 2 * L) begin
          ex = e.x1; ey = e.y1;
        end
        ev = (mon_cyc == e.k + 2 * L + 4);
      end
      check("mul_x", mul_x, ex);
      check("mul_y", mul_y, ey);
      check("rpm_valid", rpm_valid, ev);
      if (ev) begin
        pub_rpm0 = e.rpm0;
        pub_rpm1 = e.rpm1;
        pub_ovf  = e.ovf;
        void'(sb_q.pop_front());
      end
      check("rpm0", rpm0, pub_rpm0);
      check("rpm1", rpm1, pub_rpm1);
      check("rpm_ovf", rpm_ovf, pub_ovf);
    end
  end

  // ---------------- stimulus and reference model ----------------
  int want[2];
  int force_off[2];
  bit a_lvl[2];
  bit b_lvl[2];
  int ph[2];
  int rev_acc[64][2];
  bit rand_mode = 1'b0;

  function automatic void expect_rpm(input int revs, input int gr,
                                     output logic [7:0] val, output logic ovf);
    int prod;
    prod = revs * gr;
    val  = 8'(prod);
    ovf  = 1'b0;
`ifdef MOTOR_SPEED_SAT_EN
    if (prod > 127) begin
      val = 8'h7F; ovf = 1'b1;
    end else if (prod < -128) begin
      val = 8'h80; ovf = 1'b1;
    end
`endif
  endfunction

  function automatic logic [7:0] mag(input int v);
    return 8'((v < 0) ? -v : v);
  endfunction

  // A rise driven in cycle c is seen by the counter in cycle c+2; the window
  // ending at TC cycle w*G+G-1 owns events in cycles [w*G-1, w*G+G-2].
  function automatic void model_edge(input int ch, input int c);
    int w;
    w = ((c + 3) / G) % 64;
    ph[ch]++;
    if (ph[ch] == EPR) begin
      ph[ch] = 0;
      if (b_lvl[ch]) begin
        if (rev_acc[w][ch] > -128) rev_acc[w][ch]--;
      end else begin
        if (rev_acc[w][ch] < 127) rev_acc[w][ch]++;
      end
    end
  endfunction

  function automatic void push_window(input int w, input int c);
    exp_t       e;
    logic       o0, o1;
    int         r0, r1;
    r0   = rev_acc[w % 64][0];
    r1   = rev_acc[w % 64][1];
    e.k  = c;
    e.x0 = mag(r0);
    e.y0 = gr0;
    e.x1 = mag(r1);
    e.y1 = gr1;
    expect_rpm(r0, int'(gr0), e.rpm0, o0);
    expect_rpm(r1, int'(gr1), e.rpm1, o1);
    e.ovf = {o1, o0};
    sb_q.push_back(e);
  endfunction

  task automatic clear_model();
    for (int ch = 0; ch < 2; ch++) begin
      want[ch] = 0; force_off[ch] = -1; a_lvl[ch] = 1'b0; ph[ch] = 0;
    end
    for (int w = 0; w < 64; w++) begin
      rev_acc[w][0] = 0; rev_acc[w][1] = 0;
    end
    a0 = 1'b0; a1 = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    clear_model();
    repeat (n) @(negedge cclk);
    rst = 1'b0;
  endtask

  // Drive one cycle's inputs (called at a negedge), then advance.
  task automatic step();
    int c;
    c = mon_cyc;
    if (rand_mode) begin
      for (int ch = 0; ch < 2; ch++)
        if ($urandom_range(0, 15) == 0) b_lvl[ch] = ~b_lvl[ch];
      if ($urandom_range(0, 63) == 0) gr0 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 63) == 0) gr1 = 8'($urandom_range(0, 255));
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (a_lvl[ch]) begin
        a_lvl[ch] = 1'b0;
      end else if (want[ch] > 0) begin
        a_lvl[ch] = 1'b1; want[ch]--; model_edge(ch, c);
      end else if (force_off[ch] == c % G) begin
        a_lvl[ch] = 1'b1; force_off[ch] = -1; model_edge(ch, c);
      end
    end
    a0 = a_lvl[0]; b0 = b_lvl[0];
    a1 = a_lvl[1]; b1 = b_lvl[1];
    if (c % G == G - 1) push_window(c / G, c);
    @(negedge cclk);
  endtask

  task automatic run_window(input int n0, input int n1, input bit bv0, input bit bv1,
                            input int g0, input int g1, input int f0);
    want[0] = n0; want[1] = n1;
    b_lvl[0] = bv0; b_lvl[1] = bv1;
    gr0 = 8'(g0); gr1 = 8'(g1);
    force_off[0] = f0; force_off[1] = -1;
    repeat (G) step();
  endtask

  initial begin
    int n_pre;
    clear_model();
    b_lvl[0] = 1'b0; b_lvl[1] = 1'b0;
    do_reset(3);
    run_window(0, 0, 0, 0, 0, 0, -1);      // idle window: zeros published
    run_window(8, 0, 0, 0, 10, 10, -1);    // 2 revs fwd * 10 -> +20
    run_window(0, 12, 0, 1, 10, 10, -1);   // 3 revs rev * 10 -> -30, mul_x=3
    run_window(12, 0, 0, 0, 50, 10, -1);   // 3 * 50 = 150: out of range
    // Bring phase to EPR-1 plus one full rev, then a rise whose revolution
    // lands exactly in the TC cycle and must carry into the next window.
    n_pre = ((EPR - 1 - ph[0]) % EPR) + EPR;
    run_window(n_pre, 0, 0, 0, 1, 0, G - 3);
    run_window(0, 0, 0, 0, 1, 0, -1);      // shows the carried +1
    rand_mode = 1'b1;
    repeat (8)
      run_window($urandom_range(0, 24), $urandom_range(0, 24),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 255), $urandom_range(0, 255), -1);
    rand_mode = 1'b0;
    // Reset during WAIT1 of the sequence started at the last TC.
    want[0] = 0; want[1] = 0;
    repeat (4) step();
    do_reset(1);
    run_window(9, 6, 1, 0, 7, 20, -1);
    run_window(5, 16, 0, 1, 3, 33, -1);
    repeat (2 * L + 8) step();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
